// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module : audio_pkg
// Brief  : Shared types and constants for the codec serial audio path.
// Rev    : 1.0  initial release
// ============================================================================
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } rx_state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module : sync_edge
// Brief  : Multi-flop synchronizer with a one-clk rising-edge pulse output.
// Rev    : 1.0  initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_central,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/i2s_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module : i2s_rx_deserializer
// Brief  : I2S receiver; oversamples bclk/lrclk/sdata in the clk domain and
//          presents complete left/right sample pairs.
// Rev    : 1.0  initial release
// ============================================================================
module i2s_rx_deserializer
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_central,
    input  logic              bclk_in,
    input  logic              lrclk_in,
    input  logic              sdata_in,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    output logic              frame_err
);

    localparam int                CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DATA_W - 1);

    logic w_bit_tick;
    logic w_lr_sync;
    logic w_sd_sync;
    logic w_bclk_sync_unused;
    logic w_lr_rise_unused;
    logic w_sd_rise_unused;
    logic w_lr_edge;
    logic [DATA_W-1:0] w_sr_shift;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk           (clk),
        .reset_central (reset_central),
        .d_i           (bclk_in),
        .sync_o        (w_bclk_sync_unused),
        .rise_o        (w_bit_tick)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk           (clk),
        .reset_central (reset_central),
        .d_i           (lrclk_in),
        .sync_o        (w_lr_sync),
        .rise_o        (w_lr_rise_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk           (clk),
        .reset_central (reset_central),
        .d_i           (sdata_in),
        .sync_o        (w_sd_sync),
        .rise_o        (w_sd_rise_unused)
    );

    rx_state_e          state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ch_q,       ch_d;
    logic               lr_prev_q,  lr_prev_d;
    logic               left_ok_q,  left_ok_d;
    logic [DATA_W-1:0]  sr_q,       sr_d;
    logic [DATA_W-1:0]  hold_l_q,   hold_l_d;
    logic [DATA_W-1:0]  sample_l_q, sample_l_d;
    logic [DATA_W-1:0]  sample_r_q, sample_r_d;
    logic               valid_q,    valid_d;
    logic               ferr_q,     ferr_d;

    assign w_lr_edge  = w_bit_tick && (w_lr_sync != lr_prev_q);
    assign w_sr_shift = {sr_q[DATA_W-2:0], w_sd_sync};

    // The tick that reveals an lrclk change carries the I2S delay bit; it is
    // consumed by the transition into SKIP, which only re-arms the counter
    // for one clk so the MSB on the following tick is captured in SHIFT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        lr_prev_d  = lr_prev_q;
        left_ok_d  = left_ok_q;
        sr_d       = sr_q;
        hold_l_d   = hold_l_q;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        if (state_q == ST_SKIP) begin
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end

        if (w_bit_tick) begin
            lr_prev_d = w_lr_sync;
            case (state_q)
                ST_IDLE: begin
                    if (lr_prev_q == CH_RIGHT && w_lr_sync == CH_LEFT) begin
                        state_d = ST_SKIP;
                        ch_d    = w_lr_sync;
                    end
                end
                ST_SHIFT: begin
                    sr_d  = w_sr_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_cnt_last) begin
                        // With exact-width slots the last bit shares its tick
                        // with the next word's lrclk change.
                        if (w_lr_edge) begin
                            state_d = ST_SKIP;
                            ch_d    = w_lr_sync;
                        end else begin
                            state_d = ST_WAIT;
                        end
                        if (ch_q == CH_LEFT) begin
                            hold_l_d  = w_sr_shift;
                            left_ok_d = 1'b1;
                        end else if (left_ok_q) begin
                            sample_l_d = hold_l_q;
                            sample_r_d = w_sr_shift;
                            valid_d    = 1'b1;
                            left_ok_d  = 1'b0;
                        end
                    end else if (w_lr_edge) begin
                        ferr_d    = 1'b1;
                        left_ok_d = 1'b0;
                        state_d   = ST_SKIP;
                        ch_d      = w_lr_sync;
                    end
                end
                ST_WAIT: begin
                    if (w_lr_edge) begin
                        state_d = ST_SKIP;
                        ch_d    = w_lr_sync;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ch_q       <= CH_LEFT;
            lr_prev_q  <= 1'b0;
            left_ok_q  <= 1'b0;
            sr_q       <= '0;
            hold_l_q   <= '0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            lr_prev_q  <= lr_prev_d;
            left_ok_q  <= left_ok_d;
            sr_q       <= sr_d;
            hold_l_q   <= hold_l_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;

endmodule : i2s_rx_deserializer
`default_nettype wire

// File: tb/tb_i2s_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_rx_deserializer
// Brief  : Scoreboard bench for the I2S receiver driven by directed frames.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2s_rx_deserializer;

    logic        clk;
    logic        reset_central;
    logic        bclk_in;
    logic        lrclk_in;
    logic        sdata_in;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        frame_err;

    int checks;
    int errors;
    int fe_count;
    int half_ns;
    logic carry;
    logic [31:0] exp_q[$];

    i2s_rx_deserializer #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_central (reset_central),
        .bclk_in       (bclk_in),
        .lrclk_in      (lrclk_in),
        .sdata_in      (sdata_in),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bclk period; lrclk/sdata change with the falling edge.
    task automatic tick_bit(input logic lr, input logic d);
        lrclk_in = lr;
        sdata_in = d;
        #(half_ns) bclk_in = 1'b1;
        #(half_ns) bclk_in = 1'b0;
    endtask

    task automatic send_slot(input logic ch, input logic [15:0] val,
                             input int slot, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            logic d;
            if (k == 0)       d = carry;
            else if (k <= 16) d = val[16-k];
            else              d = 1'b0;
            tick_bit(ch, d);
        end
        carry = (slot == 16 && nbits == slot) ? val[0] : 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int slot, input bit expect_pair);
        if (expect_pair) exp_q.push_back({l, r});
        send_slot(1'b0, l, slot, slot);
        send_slot(1'b1, r, slot, slot);
    endtask

    task automatic preamble(input int n);
        repeat (n) tick_bit(1'b1, 1'b0);
        carry = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every sample_valid pulse.
    initial begin : monitor
        logic [15:0] last_l, last_r, prev_l, prev_r;
        logic        prev_valid, prev_fe;
        logic [31:0] e;
        last_l = '0; last_r = '0; prev_l = '0; prev_r = '0;
        prev_valid = 1'b0; prev_fe = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_central) begin
                last_l = '0; last_r = '0; prev_valid = 1'b0; prev_fe = 1'b0;
            end else begin
                if (sample_valid || frame_err) begin
                    checks++;
                    if (sample_valid && frame_err) begin
                        errors++;
                        $display("FAIL overlap: sample_valid=%b frame_err=%b both high", sample_valid, frame_err);
                    end
                end
                if (sample_valid) begin
                    checks++;
                    if (prev_valid) begin
                        errors++;
                        $display("FAIL valid_width: sample_valid high %0d consecutive clks, expected 1", 2);
                    end
                    chk("hold_l", prev_l, last_l);
                    chk("hold_r", prev_r, last_r);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: got L=%h R=%h, expected no pulse", sample_l, sample_r);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sample_l", sample_l, e[31:16]);
                        chk("sample_r", sample_r, e[15:0]);
                        last_l = e[31:16];
                        last_r = e[15:0];
                    end
                end
                if (frame_err) begin
                    fe_count++;
                    checks++;
                    if (prev_fe) begin
                        errors++;
                        $display("FAIL ferr_width: frame_err high 2 consecutive clks, expected 1");
                    end
                end
                prev_valid = sample_valid;
                prev_fe    = frame_err;
            end
            prev_l = sample_l;
            prev_r = sample_r;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        checks = 0; errors = 0; fe_count = 0;
        half_ns = 40; carry = 1'b0;
        reset_central = 1'b1;
        bclk_in = 1'b0; lrclk_in = 1'b0; sdata_in = 1'b0;
        #23;
        chk("rst_sample_l", sample_l, 16'h0000);
        chk("rst_sample_r", sample_r, 16'h0000);
        chk("rst_valid", {15'd0, sample_valid}, 16'h0000);
        chk("rst_ferr", {15'd0, frame_err}, 16'h0000);
        #30 reset_central = 1'b0;

        // 1: single stereo frame, 32-bit slots, clk = 8x bclk
        preamble(4);
        send_frame(16'hA5C3, 16'h0F0F, 32, 1);

        // 2: three back-to-back frames
        send_frame(16'h1234, 16'h8001, 32, 1);
        send_frame(16'hFFFF, 16'h0000, 32, 1);
        send_frame(16'h7FFF, 16'h8000, 32, 1);
        #400;

        // 3: reset, then join in the middle of a right word
        reset_central = 1'b1;
        #1;
        chk("t3_rst_l", sample_l, 16'h0000);
        chk("t3_rst_r", sample_r, 16'h0000);
        #40 reset_central = 1'b0;
        carry = 1'b0;
        send_slot(1'b1, 16'hBEEF, 32, 20);
        send_frame(16'h3C3C, 16'hC3C3, 32, 1);

        // 4: left word cut short after 10 bits, orphan right word, then good frame
        send_slot(1'b0, 16'hFFFF, 32, 11);
        send_slot(1'b1, 16'h1111, 32, 32);
        send_frame(16'h5555, 16'hAAAA, 32, 1);
        #400;

        // 5: async reset during bit 8 of a right word
        send_slot(1'b0, 16'h1357, 32, 32);
        send_slot(1'b1, 16'h2468, 32, 9);
        reset_central = 1'b1;
        #1;
        chk("t5_rst_l", sample_l, 16'h0000);
        chk("t5_rst_r", sample_r, 16'h0000);
        chk("t5_rst_valid", {15'd0, sample_valid}, 16'h0000);
        #40 reset_central = 1'b0;
        preamble(6);
        send_frame(16'h9ABC, 16'hDEF0, 32, 1);

        // 6: exact 16-bit slots, clk = 4x bclk
        half_ns = 20;
        send_frame(16'h8000, 16'h0001, 16, 1);
        send_frame(16'h00FF, 16'hFF01, 16, 1);
        tick_bit(1'b0, carry);
        repeat (4) tick_bit(1'b0, 1'b0);
        #500;

        chk("pending_pairs", 16'(exp_q.size()), 16'd0);
        chk("frame_err_count", 16'(fe_count), 16'd1);
        chk("final_l", sample_l, 16'h00FF);
        chk("final_r", sample_r, 16'hFF01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_i2s_rx_deserializer
`default_nettype wire
